// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared opcodes, header layout, error codes and FSM states for cmd_dispatcher
package cmd_pkg;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_DRAW_TRI = 8'h02;
    localparam logic [7:0] OP_SIMD     = 8'h03;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  flags;
        logic [15:0] len;
    } cmd_header_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_OP   = 2'd1,
        ERR_OVERSIZE = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_DRAIN,
        ST_DISPATCH,
        ST_WAIT
    } state_e;

endpackage

// File: rtl/cmd_payload_buf.sv
// rtl/cmd_payload_buf.sv - write-indexed payload register array with word count and count clear
module cmd_payload_buf #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [31:0]                wr_data,
    output logic [DEPTH*32-1:0]        data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear only rewinds the count; stale words stay until overwritten.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (wr_en && (count_q < CNT_W'(DEPTH))) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (count_q == CNT_W'(i)) begin
                    mem_d[i] = wr_data;
                end
            end
            count_d = count_q + 1'b1;
        end
    end

    // Buffer and count registers, zeroed on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    // Flatten the array, word i at [32*i +: 32].
    always_comb begin
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            data[32*i +: 32] = mem_q[i];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cmd_dispatcher.sv
// rtl/cmd_dispatcher.sv - header/payload command dispatcher to start/done engines; CMD_TIMEOUT_EN adds a WAIT watchdog
module cmd_dispatcher
    import cmd_pkg::*;
#(
    parameter int NUM_ENG        = 3,
    parameter int MAX_PAYLOAD    = 8,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    input  logic [31:0]                      cmd_data,
    output logic                             cmd_ready,
    output logic [NUM_ENG-1:0]               eng_start,
    input  logic [NUM_ENG-1:0]               eng_done,
    output logic [7:0]                       eng_flags,
    output logic [MAX_PAYLOAD*32-1:0]        payload_data,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0] payload_count,
    output logic                             busy,
    output logic                             err_valid,
    output logic [1:0]                       err_code,
    output logic [31:0]                      cmds_done
);
    state_e             state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   drain_q, drain_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [NUM_ENG-1:0] eng_start_q, eng_start_d;
    logic [7:0]         eng_flags_q, eng_flags_d;
    logic               busy_q, busy_d;
    logic               err_valid_q, err_valid_d;
    err_code_e          err_code_q, err_code_d;
    logic [31:0]        cmds_done_q, cmds_done_d;
`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]      wait_cnt_q, wait_cnt_d;
`endif

    cmd_header_t      hdr;
    logic [LEN_W-1:0] hdr_len;
    logic             accept;
    logic             done_sel;
    logic             buf_clr;
    logic             buf_wr;

    assign hdr     = cmd_data;
    assign hdr_len = hdr.len[LEN_W-1:0];
    assign accept  = cmd_valid && cmd_ready_q;

    cmd_payload_buf #(.DEPTH(MAX_PAYLOAD)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (cmd_data),
        .data    (payload_data),
        .count   (payload_count)
    );

    // Next-state and next-output logic; every output is registered from its _d.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        drain_d     = drain_q;
        eng_flags_d = eng_flags_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        cmds_done_d = cmds_done_q;
        buf_clr     = 1'b0;
        buf_wr      = 1'b0;
`ifdef CMD_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        done_sel = 1'b0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (op_q == 8'(i + 1)) begin
                done_sel = eng_done[i];
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d        = hdr.opcode;
                    len_d       = hdr_len;
                    drain_d     = hdr_len;
                    eng_flags_d = hdr.flags;
                    if (hdr.opcode == OP_NOP) begin
                        cmds_done_d = cmds_done_q + 32'd1;
                        if (hdr_len != '0) state_d = ST_DRAIN;
                    end else if (hdr.opcode > 8'(NUM_ENG)) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_BAD_OP;
                        if (hdr_len != '0) state_d = ST_DRAIN;
                    end else if (hdr_len > LEN_W'(MAX_PAYLOAD)) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_OVERSIZE;
                        state_d     = ST_DRAIN;
                    end else if (hdr_len == '0) begin
                        state_d = ST_DISPATCH;
                    end else begin
                        buf_clr = 1'b1;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    buf_wr = 1'b1;
                    if (LEN_W'(payload_count) + 1'b1 == len_q) state_d = ST_DISPATCH;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    drain_d = drain_q - 1'b1;
                    if (drain_q == LEN_W'(1)) state_d = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                state_d = ST_WAIT;
`ifdef CMD_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                // A done coinciding with expiry wins over the timeout.
                if (done_sel) begin
                    cmds_done_d = cmds_done_q + 32'd1;
                    state_d     = ST_IDLE;
`ifdef CMD_TIMEOUT_EN
                end else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) eng_flags_d = '0;
        cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_PAYLOAD) || (state_d == ST_DRAIN);
        busy_d      = (state_d != ST_IDLE);
        eng_start_d = '0;
        if (state_d == ST_DISPATCH) begin
            for (int i = 0; i < NUM_ENG; i++) begin
                eng_start_d[i] = (op_d == 8'(i + 1));
            end
        end
    end

    // Single state/output register bank; reset abandons any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            len_q       <= '0;
            drain_q     <= '0;
            cmd_ready_q <= 1'b0;
            eng_start_q <= '0;
            eng_flags_q <= '0;
            busy_q      <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            cmds_done_q <= '0;
`ifdef CMD_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            len_q       <= len_d;
            drain_q     <= drain_d;
            cmd_ready_q <= cmd_ready_d;
            eng_start_q <= eng_start_d;
            eng_flags_q <= eng_flags_d;
            busy_q      <= busy_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            cmds_done_q <= cmds_done_d;
`ifdef CMD_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign eng_start = eng_start_q;
    assign eng_flags = eng_flags_q;
    assign busy      = busy_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign cmds_done = cmds_done_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb/tb_cmd_dispatcher.sv - randomized bench with stream-level reference model for cmd_dispatcher
module tb_cmd_dispatcher;
    localparam int NE   = 3;
    localparam int MAXP = 8;
    localparam int TO   = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [31:0]  cmd_data = '0;
    logic         cmd_ready;
    logic [2:0]   eng_start;
    logic [2:0]   eng_done = '0;
    logic [7:0]   eng_flags;
    logic [255:0] payload_data;
    logic [3:0]   payload_count;
    logic         busy;
    logic         err_valid;
    logic [1:0]   err_code;
    logic [31:0]  cmds_done;

    int n_total = 0;
    int n_pass  = 0;
    bit mute    = 1'b0;

    cmd_dispatcher #(.NUM_ENG(NE), .MAX_PAYLOAD(MAXP), .LEN_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .eng_start(eng_start), .eng_done(eng_done),
        .eng_flags(eng_flags), .payload_data(payload_data), .payload_count(payload_count),
        .busy(busy), .err_valid(err_valid), .err_code(err_code), .cmds_done(cmds_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: parses the accepted stream and predicts next-cycle outputs.
    logic [2:0]  m_start = '0;
    logic        m_err_v = 1'b0;
    logic [1:0]  m_err_c = '0;
    logic [31:0] m_cmds = '0;
    logic        m_ready = 1'b0;
    logic        m_busy = 1'b0;
    int          m_count = 0;
    logic [31:0] m_buf [MAXP];
    int          rem = 0;
    bit          collecting = 1'b0;
    bit          blocked = 1'b0;
    int          cur_eng = 0;
    logic [7:0]  cur_flags = '0;
    int          wc = 0;

    initial begin : compare
        logic [2:0] n_start;
        logic       n_err_v;
        int         op;
        int         ln;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_cmd_ready", 32'(cmd_ready), 0);
                check("rst_eng_start", 32'(eng_start), 0);
                check("rst_eng_flags", 32'(eng_flags), 0);
                check("rst_payload_count", 32'(payload_count), 0);
                check("rst_payload_nonzero", 32'(|payload_data), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_err_valid", 32'(err_valid), 0);
                check("rst_err_code", 32'(err_code), 0);
                check("rst_cmds_done", cmds_done, 0);
                m_start = '0; m_err_v = 0; m_err_c = '0; m_cmds = '0; m_ready = 0; m_busy = 0;
                m_count = 0; rem = 0; collecting = 0; blocked = 0;
                for (int i = 0; i < MAXP; i++) m_buf[i] = '0;
            end else begin
                check("eng_start", 32'(eng_start), 32'(m_start));
                check("err_valid", 32'(err_valid), 32'(m_err_v));
                check("err_code", 32'(err_code), 32'(m_err_c));
                check("cmds_done", cmds_done, m_cmds);
                check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
                check("busy", 32'(busy), 32'(m_busy));
                check("payload_count", 32'(payload_count), 32'(m_count));
                for (int i = 0; i < m_count; i++) check($sformatf("payload_word%0d", i), payload_data[32*i +: 32], m_buf[i]);
                if (m_start != 0) check("eng_flags", 32'(eng_flags), 32'(cur_flags));

                n_start = '0;
                n_err_v = 1'b0;
                if (blocked && m_start == 0) begin
                    if (eng_done[cur_eng]) begin
                        m_cmds = m_cmds + 1;
                        blocked = 0;
                    end
`ifdef CMD_TIMEOUT_EN
                    else begin
                        wc++;
                        if (wc == TO) begin
                            n_err_v = 1'b1; m_err_c = 2'd3; blocked = 0;
                        end
                    end
`endif
                end
                if (cmd_valid && cmd_ready) begin
                    if (rem == 0) begin
                        op = int'(cmd_data[31:24]);
                        ln = int'(cmd_data[15:0]);
                        rem = ln;
                        collecting = 0;
                        if (op == 0) m_cmds = m_cmds + 1;
                        else if (op > NE) begin n_err_v = 1'b1; m_err_c = 2'd1; end
                        else if (ln > MAXP) begin n_err_v = 1'b1; m_err_c = 2'd2; end
                        else begin
                            collecting = 1;
                            cur_eng = op - 1;
                            cur_flags = cmd_data[23:16];
                            if (ln == 0) begin n_start = 3'(1 << cur_eng); blocked = 1; wc = 0; end
                            else m_count = 0;
                        end
                    end else begin
                        rem--;
                        if (collecting) begin
                            m_buf[m_count] = cmd_data;
                            m_count++;
                            if (rem == 0) begin n_start = 3'(1 << cur_eng); blocked = 1; wc = 0; end
                        end
                    end
                end
                m_start = n_start;
                m_err_v = n_err_v;
                m_ready = !blocked;
                m_busy  = (rem > 0) || blocked;
            end
        end
    end

    // Engine model: random completion delay plus sparse noise on done bits that must be ignored.
    initial begin : responder
        int         busy_e;
        int         dly;
        logic [2:0] nz;
        busy_e = -1;
        dly = 0;
        forever begin
            @(posedge clk); #1;
            nz = 3'($urandom) & 3'($urandom) & 3'($urandom);
            if (!rst_n) begin
                busy_e = -1;
                eng_done = '0;
            end else if (eng_start != 0) begin
                for (int i = 0; i < NE; i++) if (eng_start[i]) busy_e = i;
                dly = $urandom_range(0, 8);
                eng_done = nz;
            end else if (busy_e >= 0) begin
                if (dly == 0 && !mute) begin
                    eng_done = nz | 3'(1 << busy_e);
                    busy_e = -1;
                end else begin
                    eng_done = nz & ~3'(1 << busy_e);
                    if (dly > 0) dly--;
                end
            end else begin
                eng_done = nz;
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int t;
        if ($urandom_range(0, 3) == 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        cmd_valid = 1'b1;
        cmd_data = w;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
        if (!cmd_ready) begin
            n_total++;
            $display("FAIL send_timeout: cmd_ready stayed 0 for word %0h", w);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data = $urandom;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(cmd_ready && !busy) && t < 300) begin @(negedge clk); t++; end
        if (!(cmd_ready && !busy)) begin
            n_total++;
            $display("FAIL idle_timeout: busy=%0d cmd_ready=%0d", busy, cmd_ready);
        end
    endtask

    task automatic realign();
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin : driver
        logic [31:0] draw [6];
        logic [7:0]  op;
        logic [15:0] ln;
        logic [31:0] c0;
        int          sel;
        draw[0] = 10; draw[1] = 10; draw[2] = 50; draw[3] = 10; draw[4] = 30; draw[5] = 40;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send_word(32'h0100_0000);
        wait_idle();
        check("clear_cmds_done", cmds_done, 32'd1);
        realign();

        send_word(32'h0200_0006);
        for (int i = 0; i < 6; i++) send_word(draw[i]);
        wait_idle();
        check("draw_cmds_done", cmds_done, 32'd2);
        check("draw_count", 32'(payload_count), 32'd6);
        check("draw_word2", payload_data[64 +: 32], 32'd50);
        check("draw_word5", payload_data[160 +: 32], 32'd40);
        realign();

        send_word(32'h0700_0002);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        wait_idle();
        check("badop_err_code", 32'(err_code), 32'd1);
        check("badop_cmds_done", cmds_done, 32'd2);
        realign();

        send_word(32'h0200_0009);
        for (int i = 0; i < 9; i++) send_word(32'hA000_0000 + 32'(i));
        wait_idle();
        check("oversize_err_code", 32'(err_code), 32'd2);
        check("oversize_count_kept", 32'(payload_count), 32'd6);
        check("oversize_word0_kept", payload_data[31:0], 32'd10);
        realign();

        send_word(32'h0200_0006);
        for (int i = 0; i < 3; i++) send_word(draw[i]);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cmds_done", cmds_done, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_word(32'h0100_0000);
        wait_idle();
        check("postrst_cmds_done", cmds_done, 32'd1);
        realign();

        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) op = 8'h00;
            else if (sel < 8) op = 8'($urandom_range(1, 3));
            else op = 8'($urandom_range(4, 255));
            if ($urandom_range(0, 5) == 0) ln = 16'($urandom_range(9, 11));
            else ln = 16'($urandom_range(0, 8));
            send_word({op, 8'($urandom), ln});
            for (int j = 0; j < int'(ln); j++) send_word($urandom);
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                realign();
            end
        end
        wait_idle();
        realign();

`ifdef CMD_TIMEOUT_EN
        c0 = cmds_done;
        mute = 1'b1;
        send_word(32'h0300_0000);
        wait_idle();
        check("timeout_err_code", 32'(err_code), 32'd3);
        check("timeout_cmds_done", cmds_done, c0);
        mute = 1'b0;
        realign();
`else
        c0 = cmds_done;
        send_word(32'h0000_0000);
        wait_idle();
        check("nop_cmds_done", cmds_done, c0 + 32'd1);
        realign();
`endif

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
